// File: rtl/cim_pkg.sv
// Shared definitions for the compute-in-memory row controller.
// Contents: command opcode constants, controller state encoding, and a
// helper telling whether a state drives a word-line pulse into the bank.
package cim_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ACCUM = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR_S  = 3'd1,
    WR_S   = 3'd2,
    RD_S   = 3'd3,
    ACC_RD = 3'd4,
    ACC_WR = 3'd5,
    RSP    = 3'd6
  } state_e;

  // True for every state that touches the array (one word-line group active).
  function automatic logic is_array_state(input state_e s);
    return (s == CLR_S) || (s == WR_S) || (s == RD_S) ||
           (s == ACC_RD) || (s == ACC_WR);
  endfunction

endpackage

// File: rtl/cim_row_ctrl_if.sv
// Command / response channel between the convolution datapath (master) and
// the CIM row controller (slave).
// Ports: cmd_valid/cmd_ready/cmd_op/cmd_row/cmd_data (command),
//        rsp_valid/rsp_ready/rsp_data/rsp_carry/rsp_err (response).
interface cim_row_ctrl_if #(
  parameter int ROWS  = 8,
  parameter int WIDTH = 8
);
  localparam int ADDR_W = $clog2(ROWS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_row;
  logic [WIDTH-1:0]  cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_carry;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/cim_row_decoder.sv
// Row address to one-hot word-line select.
// Ports: i_row (row address), i_en (enable), o_onehot (ROWS-bit select).
// Output is all-zero when disabled or when i_row addresses a missing row.
module cim_row_decoder #(
  parameter int ROWS   = 8,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic [ADDR_W-1:0] i_row,
  input  logic              i_en,
  output logic [ROWS-1:0]   o_onehot
);

  // Compare against each existing row; rows >= ROWS simply never match.
  always_comb begin
    o_onehot = {ROWS{1'b0}};
    for (int i = 0; i < ROWS; i++) begin
      if (i_en && (i_row == ADDR_W'(i))) begin
        o_onehot[i] = 1'b1;
      end else begin
        o_onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cim_row_ctrl.sv
// Command sequencer for a ROWS x WIDTH bank of stdCell CIM cells.
// Ports: clk, rst (async active-high); bus (command/response channel);
//        rwl/wwl/gwl/clr per-row word lines, read_en/write_en cell strobes,
//        bl bitline data, sa sense-amp inputs, to_adder/from_adder add path.
// Every array-facing output is registered from the next state, so each pulse
// lines up exactly with the state that owns it.
module cim_row_ctrl
  import cim_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  cim_row_ctrl_if.slave    bus,
  output logic [ROWS-1:0]  rwl,
  output logic [ROWS-1:0]  wwl,
  output logic [ROWS-1:0]  gwl,
  output logic [ROWS-1:0]  clr,
  output logic             read_en,
  output logic             write_en,
  output logic [WIDTH-1:0] bl,
  input  logic [WIDTH-1:0] sa,
  input  logic [WIDTH-1:0] to_adder,
  output logic [WIDTH-1:0] from_adder
);

  localparam int ADDR_W = $clog2(ROWS);
  localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(ROWS);

  function automatic logic [WIDTH:0] acc_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_row, w_row;
  logic [WIDTH-1:0]  r_data, w_data;
  logic              r_acc_carry;
  logic              w_accept, w_row_ok;
  logic [ROWS-1:0]   w_onehot;
  logic [WIDTH:0]    w_sum;

  logic [ROWS-1:0]   r_rwl, r_wwl, r_gwl, r_clr;
  logic [ROWS-1:0]   w_rwl_n, w_wwl_n, w_gwl_n, w_clr_n;
  logic              r_read_en, r_write_en, w_read_en_n, w_write_en_n;
  logic [WIDTH-1:0]  r_bl, r_from_adder, w_bl_n, w_from_adder_n;
  logic              r_rsp_valid, r_rsp_carry, r_rsp_err, r_cmd_ready;
  logic              w_rsp_valid_n, w_rsp_carry_n, w_rsp_err_n, w_cmd_ready_n;
  logic [WIDTH-1:0]  r_rsp_data, w_rsp_data_n;

  assign w_accept = bus.cmd_valid & r_cmd_ready;
  assign w_sum    = acc_add(to_adder, r_data);
  assign w_row_ok = ({1'b0, w_row} < ROWS_L);

  // In IDLE the command is still on the bus; afterwards use the latched copy.
  always_comb begin
    if (r_state == IDLE) begin
      w_row  = bus.cmd_row;
      w_data = bus.cmd_data;
    end else begin
      w_row  = r_row;
      w_data = r_data;
    end
  end

  cim_row_decoder #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_dec (
    .i_row    (w_row),
    .i_en     (is_array_state(w_next)),
    .o_onehot (w_onehot)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_row_ok) begin
          w_next = RSP;
        end else if (w_accept) begin
          case (bus.cmd_op)
            OP_CLEAR: w_next = CLR_S;
            OP_WRITE: w_next = WR_S;
            OP_READ:  w_next = RD_S;
            OP_ACCUM: w_next = ACC_RD;
            default:  w_next = IDLE;
          endcase
        end else begin
          w_next = IDLE;
        end
      end
      CLR_S, WR_S, RD_S, ACC_WR: w_next = RSP;
      ACC_RD:                    w_next = ACC_WR;
      RSP: begin
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end else begin
          w_next = RSP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, keyed on the state being entered.
  always_comb begin
    w_rwl_n        = {ROWS{1'b0}};
    w_wwl_n        = {ROWS{1'b0}};
    w_gwl_n        = {ROWS{1'b0}};
    w_clr_n        = {ROWS{1'b0}};
    w_read_en_n    = 1'b0;
    w_write_en_n   = 1'b0;
    w_bl_n         = {WIDTH{1'b0}};
    w_from_adder_n = {WIDTH{1'b0}};
    w_rsp_valid_n  = 1'b0;
    w_rsp_data_n   = {WIDTH{1'b0}};
    w_rsp_carry_n  = 1'b0;
    w_rsp_err_n    = 1'b0;
    w_cmd_ready_n  = (w_next == IDLE);
    case (w_next)
      CLR_S:  w_clr_n = w_onehot;
      WR_S: begin
        w_gwl_n      = w_onehot;
        w_write_en_n = 1'b1;
        w_bl_n       = w_data;
      end
      RD_S: begin
        w_gwl_n     = w_onehot;
        w_read_en_n = 1'b1;
      end
      ACC_RD: w_rwl_n = w_onehot;
      ACC_WR: begin
        // to_adder is valid during ACC_RD, so the sum is formed here and
        // presented to the cells throughout ACC_WR.
        w_wwl_n        = w_onehot;
        w_from_adder_n = w_sum[WIDTH-1:0];
      end
      RSP: begin
        w_rsp_valid_n = 1'b1;
        case (r_state)
          WR_S:   w_rsp_data_n = r_data;
          RD_S:   w_rsp_data_n = sa;
          ACC_WR: begin
            w_rsp_data_n  = r_from_adder;
            w_rsp_carry_n = r_acc_carry;
          end
          RSP: begin
            w_rsp_data_n  = r_rsp_data;
            w_rsp_carry_n = r_rsp_carry;
            w_rsp_err_n   = r_rsp_err;
          end
          IDLE:    w_rsp_err_n  = 1'b1;
          default: w_rsp_data_n = {WIDTH{1'b0}};
        endcase
      end
      default: w_cmd_ready_n = (w_next == IDLE);
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rwl        <= {ROWS{1'b0}};
      r_wwl        <= {ROWS{1'b0}};
      r_gwl        <= {ROWS{1'b0}};
      r_clr        <= {ROWS{1'b0}};
      r_read_en    <= 1'b0;
      r_write_en   <= 1'b0;
      r_bl         <= {WIDTH{1'b0}};
      r_from_adder <= {WIDTH{1'b0}};
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= {WIDTH{1'b0}};
      r_rsp_carry  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_cmd_ready  <= 1'b1;
    end else begin
      r_rwl        <= w_rwl_n;
      r_wwl        <= w_wwl_n;
      r_gwl        <= w_gwl_n;
      r_clr        <= w_clr_n;
      r_read_en    <= w_read_en_n;
      r_write_en   <= w_write_en_n;
      r_bl         <= w_bl_n;
      r_from_adder <= w_from_adder_n;
      r_rsp_valid  <= w_rsp_valid_n;
      r_rsp_data   <= w_rsp_data_n;
      r_rsp_carry  <= w_rsp_carry_n;
      r_rsp_err    <= w_rsp_err_n;
      r_cmd_ready  <= w_cmd_ready_n;
    end
  end

  // Command capture and accumulate carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row       <= {ADDR_W{1'b0}};
      r_data      <= {WIDTH{1'b0}};
      r_acc_carry <= 1'b0;
    end else begin
      if (w_accept) begin
        r_row  <= bus.cmd_row;
        r_data <= bus.cmd_data;
      end else begin
        r_row  <= r_row;
        r_data <= r_data;
      end
      if (w_next == ACC_WR) begin
        r_acc_carry <= w_sum[WIDTH];
      end else begin
        r_acc_carry <= r_acc_carry;
      end
    end
  end

  assign rwl           = r_rwl;
  assign wwl           = r_wwl;
  assign gwl           = r_gwl;
  assign clr           = r_clr;
  assign read_en       = r_read_en;
  assign write_en      = r_write_en;
  assign bl            = r_bl;
  assign from_adder    = r_from_adder;
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_cim_row_ctrl.sv
// Directed bench for cim_row_ctrl: an 8-row instance driving a behavioural
// stdCell bank, plus a 6-row instance for out-of-range addressing.
module tb_cim_row_ctrl;
  import cim_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  cim_row_ctrl_if #(.ROWS(8), .WIDTH(8)) bus ();
  cim_row_ctrl_if #(.ROWS(6), .WIDTH(8)) bus6 ();

  logic [7:0] rwl, wwl, gwl, clr, bl, sa, to_adder, from_adder;
  logic       read_en, write_en;
  logic [5:0] rwl6, wwl6, gwl6, clr6;
  logic [7:0] bl6, from_adder6;
  logic       read_en6, write_en6;
  logic [7:0] zero8;
  assign zero8 = 8'h00;

  cim_row_ctrl #(.ROWS(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rwl(rwl), .wwl(wwl), .gwl(gwl), .clr(clr),
    .read_en(read_en), .write_en(write_en), .bl(bl),
    .sa(sa), .to_adder(to_adder), .from_adder(from_adder)
  );

  cim_row_ctrl #(.ROWS(6), .WIDTH(8)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6),
    .rwl(rwl6), .wwl(wwl6), .gwl(gwl6), .clr(clr6),
    .read_en(read_en6), .write_en(write_en6), .bl(bl6),
    .sa(zero8), .to_adder(zero8), .from_adder(from_adder6)
  );

  // Behavioural stdCell bank: storage updated at the end of each pulse cycle.
  logic [7:0] mem [8];
  always @(posedge clk) begin
    for (int r = 0; r < 8; r++) begin
      if (clr[r]) mem[r] <= 8'h00;
      else if (gwl[r] && write_en) mem[r] <= bl;
      else if (wwl[r]) mem[r] <= from_adder;
    end
  end

  // Bank read paths: sense amp on gwl+read_en, ToAdder on rwl.
  always_comb begin
    sa = 8'h00;
    to_adder = 8'h00;
    for (int r = 0; r < 8; r++) begin
      if (gwl[r] && read_en) sa = mem[r];
      if (rwl[r]) to_adder = mem[r];
    end
  end

  typedef struct packed {
    int         lat;
    int         pulse_cyc;
    int         rd_cyc;
    int         wr_cyc;
    int         valid_cyc;
    logic [7:0] gwl_or, rwl_or, wwl_or, clr_or, bl_v, fa_v, data;
    logic       carry, err, unstable, multi, rdy_busy;
  } obs_t;

  // Issue one command on the 8-row instance and record what happens until
  // the response handshake completes (stall = cycles rsp_ready held low).
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] row,
                         input logic [7:0] data, input int stall, output obs_t o);
    o = '0;
    o.lat = 99;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_row = row; bus.cmd_data = data;
    bus.rsp_ready = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) bus.cmd_valid = 1'b0;
      if ($countones({rwl, wwl, gwl, clr}) > 1) o.multi = 1'b1;
      if ({rwl, wwl, gwl, clr} != 32'h0) o.pulse_cyc++;
      o.gwl_or |= gwl; o.rwl_or |= rwl; o.wwl_or |= wwl; o.clr_or |= clr;
      if (read_en) o.rd_cyc++;
      if (write_en) begin o.wr_cyc++; o.bl_v = bl; end
      if (|wwl) o.fa_v = from_adder;
      if (bus.cmd_ready) o.rdy_busy = 1'b1;
      if (bus.rsp_valid) begin
        o.valid_cyc++;
        if (o.lat == 99) begin
          o.lat = c; o.data = bus.rsp_data; o.carry = bus.rsp_carry; o.err = bus.rsp_err;
        end else if ({o.data, o.carry, o.err} != {bus.rsp_data, bus.rsp_carry, bus.rsp_err}) begin
          o.unstable = 1'b1;
        end
        if (c - o.lat >= stall) begin
          bus.rsp_ready = 1'b1;
          @(negedge clk);
          bus.rsp_ready = 1'b0;
          break;
        end
      end else if (o.lat != 99) begin
        o.unstable = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({rwl, wwl, gwl, clr} !== 32'h0) begin n_err++; $display("FAIL reset_lines: got %h expected 0", {rwl, wwl, gwl, clr}); end
    n_vec++; if ({read_en, write_en, bl, from_adder} !== 18'h0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 0", {read_en, write_en, bl, from_adder}); end
    n_vec++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_err} !== 11'h0) begin n_err++; $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_valid, bus.rsp_data}); end
    n_vec++; if ({bus.cmd_ready, bus6.cmd_ready} !== 2'b11) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 11", {bus.cmd_ready, bus6.cmd_ready}); end
  endtask

  task automatic test_write_read;
    obs_t o;
    run_cmd(OP_WRITE, 3'd3, 8'hA5, 0, o);
    n_vec++; if (o.lat !== 2) begin n_err++; $display("FAIL wr_latency: got %0d expected 2", o.lat); end
    n_vec++; if ({o.gwl_or, o.rwl_or, o.wwl_or, o.clr_or} !== 32'h08000000) begin n_err++; $display("FAIL wr_lines: got %h expected 08000000", {o.gwl_or, o.rwl_or, o.wwl_or, o.clr_or}); end
    n_vec++; if ({o.pulse_cyc, o.wr_cyc, o.rd_cyc} !== {32'd1, 32'd1, 32'd0}) begin n_err++; $display("FAIL wr_pulse_cycles: got %0d/%0d/%0d expected 1/1/0", o.pulse_cyc, o.wr_cyc, o.rd_cyc); end
    n_vec++; if (o.bl_v !== 8'hA5) begin n_err++; $display("FAIL wr_bl: got %h expected a5", o.bl_v); end
    n_vec++; if ({o.data, o.carry, o.err} !== {8'hA5, 2'b00}) begin n_err++; $display("FAIL wr_rsp: got %h/%b/%b expected a5/0/0", o.data, o.carry, o.err); end
    n_vec++; if (o.rdy_busy !== 1'b0) begin n_err++; $display("FAIL wr_cmd_ready_busy: got %b expected 0", o.rdy_busy); end
    n_vec++; if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin n_err++; $display("FAIL wr_back_idle: got %b expected 10", {bus.cmd_ready, bus.rsp_valid}); end
    run_cmd(OP_READ, 3'd3, 8'h00, 0, o);
    n_vec++; if ({o.lat, o.rd_cyc, o.wr_cyc} !== {32'd2, 32'd1, 32'd0}) begin n_err++; $display("FAIL rd_timing: got %0d/%0d/%0d expected 2/1/0", o.lat, o.rd_cyc, o.wr_cyc); end
    n_vec++; if (o.gwl_or !== 8'h08) begin n_err++; $display("FAIL rd_gwl: got %h expected 08", o.gwl_or); end
    n_vec++; if (o.data !== 8'hA5) begin n_err++; $display("FAIL rd_data: got %h expected a5", o.data); end
    // Top row boundary.
    run_cmd(OP_WRITE, 3'd7, 8'hFF, 0, o);
    n_vec++; if (o.gwl_or !== 8'h80) begin n_err++; $display("FAIL wr7_gwl: got %h expected 80", o.gwl_or); end
    run_cmd(OP_READ, 3'd7, 8'h00, 0, o);
    n_vec++; if (o.data !== 8'hFF) begin n_err++; $display("FAIL rd7_data: got %h expected ff", o.data); end
  endtask

  task automatic test_accum;
    obs_t o;
    run_cmd(OP_ACCUM, 3'd3, 8'h6B, 0, o);
    n_vec++; if (o.lat !== 3) begin n_err++; $display("FAIL acc_latency: got %0d expected 3", o.lat); end
    n_vec++; if ({o.rwl_or, o.wwl_or, o.gwl_or, o.clr_or} !== 32'h08080000) begin n_err++; $display("FAIL acc_lines: got %h expected 08080000", {o.rwl_or, o.wwl_or, o.gwl_or, o.clr_or}); end
    n_vec++; if ({o.pulse_cyc, o.multi} !== {32'd2, 1'b0}) begin n_err++; $display("FAIL acc_pulses: got %0d/%b expected 2/0", o.pulse_cyc, o.multi); end
    n_vec++; if (o.fa_v !== 8'h10) begin n_err++; $display("FAIL acc_from_adder: got %h expected 10", o.fa_v); end
    n_vec++; if ({o.data, o.carry, o.err} !== {8'h10, 1'b1, 1'b0}) begin n_err++; $display("FAIL acc_rsp: got %h/%b/%b expected 10/1/0", o.data, o.carry, o.err); end
    run_cmd(OP_READ, 3'd3, 8'h00, 0, o);
    n_vec++; if (o.data !== 8'h10) begin n_err++; $display("FAIL acc_readback: got %h expected 10", o.data); end
    run_cmd(OP_ACCUM, 3'd3, 8'h0F, 0, o);
    n_vec++; if ({o.data, o.carry} !== {8'h1F, 1'b0}) begin n_err++; $display("FAIL acc_nocarry: got %h/%b expected 1f/0", o.data, o.carry); end
  endtask

  task automatic test_clear_stall;
    obs_t o;
    run_cmd(OP_CLEAR, 3'd3, 8'h5A, 5, o);
    n_vec++; if ({o.clr_or, o.gwl_or, o.rwl_or, o.wwl_or} !== 32'h08000000) begin n_err++; $display("FAIL clr_lines: got %h expected 08000000", {o.clr_or, o.gwl_or, o.rwl_or, o.wwl_or}); end
    n_vec++; if (o.pulse_cyc !== 1) begin n_err++; $display("FAIL clr_pulse_cycles: got %0d expected 1", o.pulse_cyc); end
    n_vec++; if ({o.lat, o.valid_cyc} !== {32'd2, 32'd6}) begin n_err++; $display("FAIL clr_valid_hold: got %0d/%0d expected 2/6", o.lat, o.valid_cyc); end
    n_vec++; if ({o.data, o.carry, o.err, o.unstable} !== 11'h0) begin n_err++; $display("FAIL clr_rsp_stable: got %h/%b/%b/%b expected 00/0/0/0", o.data, o.carry, o.err, o.unstable); end
    n_vec++; if (o.rdy_busy !== 1'b0) begin n_err++; $display("FAIL clr_cmd_ready_busy: got %b expected 0", o.rdy_busy); end
    run_cmd(OP_READ, 3'd3, 8'h00, 0, o);
    n_vec++; if (o.data !== 8'h00) begin n_err++; $display("FAIL clr_readback: got %h expected 00", o.data); end
  endtask

  task automatic test_out_of_range;
    logic [2:0] bad_rows [2];
    logic [1:0] bad_ops  [2];
    bad_rows[0] = 3'd7; bad_ops[0] = OP_READ;
    bad_rows[1] = 3'd6; bad_ops[1] = OP_WRITE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus6.cmd_valid = 1'b1; bus6.cmd_op = bad_ops[k]; bus6.cmd_row = bad_rows[k];
      bus6.cmd_data = 8'h33; bus6.rsp_ready = 1'b0;
      @(negedge clk);
      bus6.cmd_valid = 1'b0;
      n_vec++; if ({bus6.rsp_valid, bus6.rsp_err, bus6.rsp_data} !== {2'b11, 8'h00}) begin n_err++; $display("FAIL oor_rsp_row%0d: got %b/%b/%h expected 1/1/00", bad_rows[k], bus6.rsp_valid, bus6.rsp_err, bus6.rsp_data); end
      n_vec++; if ({rwl6, wwl6, gwl6, clr6, read_en6, write_en6} !== 26'h0) begin n_err++; $display("FAIL oor_lines_row%0d: got %h expected 0", bad_rows[k], {rwl6, wwl6, gwl6, clr6, read_en6, write_en6}); end
      bus6.rsp_ready = 1'b1;
      @(negedge clk);
      bus6.rsp_ready = 1'b0;
      n_vec++; if ({bus6.cmd_ready, bus6.rsp_valid} !== 2'b10) begin n_err++; $display("FAIL oor_back_idle_row%0d: got %b expected 10", bad_rows[k], {bus6.cmd_ready, bus6.rsp_valid}); end
    end
    // Last real row of the 6-row bank is still legal.
    @(negedge clk);
    bus6.cmd_valid = 1'b1; bus6.cmd_op = OP_READ; bus6.cmd_row = 3'd5; bus6.cmd_data = 8'h00;
    @(negedge clk);
    bus6.cmd_valid = 1'b0;
    n_vec++; if ({gwl6, read_en6, bus6.rsp_valid} !== {6'b100000, 2'b10}) begin n_err++; $display("FAIL row5_pulse: got %b/%b/%b expected 100000/1/0", gwl6, read_en6, bus6.rsp_valid); end
    @(negedge clk);
    n_vec++; if ({bus6.rsp_valid, bus6.rsp_err} !== 2'b10) begin n_err++; $display("FAIL row5_rsp: got %b/%b expected 1/0", bus6.rsp_valid, bus6.rsp_err); end
    bus6.rsp_ready = 1'b1;
    @(negedge clk);
    bus6.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_accum;
    obs_t o;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ACCUM; bus.cmd_row = 3'd3; bus.cmd_data = 8'h01;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_vec++; if (rwl !== 8'h08) begin n_err++; $display("FAIL rst_acc_rwl: got %h expected 08", rwl); end
    @(negedge clk);
    n_vec++; if (wwl !== 8'h08) begin n_err++; $display("FAIL rst_acc_wwl_before: got %h expected 08", wwl); end
    rst = 1'b1;
    #1;
    n_vec++; if ({wwl, from_adder, bus.rsp_valid} !== 17'h0) begin n_err++; $display("FAIL rst_acc_drop: got %h expected 0", {wwl, from_adder, bus.rsp_valid}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin n_err++; $display("FAIL rst_acc_idle: got %b expected 10", {bus.cmd_ready, bus.rsp_valid}); end
    run_cmd(OP_WRITE, 3'd0, 8'h3C, 0, o);
    n_vec++; if ({o.lat, o.gwl_or, o.data} !== {32'd2, 8'h01, 8'h3C}) begin n_err++; $display("FAIL post_rst_write: got %0d/%h/%h expected 2/01/3c", o.lat, o.gwl_or, o.data); end
    run_cmd(OP_READ, 3'd0, 8'h00, 0, o);
    n_vec++; if (o.data !== 8'h3C) begin n_err++; $display("FAIL post_rst_read: got %h expected 3c", o.data); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_row = 3'd0; bus.cmd_data = 8'h00; bus.rsp_ready = 1'b0;
    bus6.cmd_valid = 1'b0; bus6.cmd_op = 2'b00; bus6.cmd_row = 3'd0; bus6.cmd_data = 8'h00; bus6.rsp_ready = 1'b0;
    rst = 1'b1;
    test_reset;
    test_write_read;
    test_accum;
    test_clear_stall;
    test_out_of_range;
    test_reset_mid_accum;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cim_row_ctrl.md
Name: cim_row_ctrl

Overview:
Command sequencer that sits directly upstream of a bank of stdCell compute-in-memory cells (ROWS rows x WIDTH columns). It turns single commands (clear, bitline write, bitline read, read-add-writeback accumulate) into correctly timed word-line and control pulses: CLR, GWL/Write/BL, GWL/READ/SA, and RWL/ToAdder -> WWL/FromAdder. It also performs the column-wide add for accumulation and returns results over a valid/ready response channel to the convolution datapath.

Parameters:
ROWS, 8, number of cell rows in the bank
WIDTH, 8, columns per row (bits per word)
ADDR_W, $clog2(ROWS), row address width (derived, not overridden)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command (IDLE only)
cmd_op  input  2  00 CLEAR, 01 WRITE, 10 READ, 11 ACCUM
cmd_row  input  ADDR_W  target row
cmd_data  input  WIDTH  write data (WRITE) or addend (ACCUM)
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_data  output  WIDTH  read value / accumulated sum / echo
rsp_carry  output  1  carry-out of ACCUM add, else 0
rsp_err  output  1  cmd_row >= ROWS; no array access was made
rwl  output  ROWS  per-row read word line (to ToAdder path)
wwl  output  ROWS  per-row write word line (from FromAdder path)
gwl  output  ROWS  per-row global word line (bitline access)
clr  output  ROWS  per-row clear
read_en  output  1  cell READ strobe to sense amp
write_en  output  1  cell Write strobe from bitline
bl  output  WIDTH  bitline write data
sa  input  WIDTH  sense-amp outputs of selected row
to_adder  input  WIDTH  ToAdder outputs of selected row
from_adder  output  WIDTH  sum driven back to cells (FromAdder)

Behaviour:
- Reset (async): state IDLE; all word lines, clr, read_en, write_en, bl, from_adder, rsp_* = 0; cmd_ready = 1 once IDLE.
- States: IDLE, CLR_S, WR_S, RD_S, ACC_RD, ACC_WR, RSP. All array outputs registered; at most one bit set across rwl|wwl|gwl|clr in any cycle; zero outside their own state.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready, latch op/row/data. Out-of-range row -> RSP with rsp_err=1, rsp_data=0, no array pulse. Else CLEAR->CLR_S, WRITE->WR_S, READ->RD_S, ACCUM->ACC_RD.
- CLR_S (1 cycle): clr[row]=1 -> RSP, rsp_data=0.
- WR_S (1 cycle): gwl[row]=1, write_en=1, bl=data -> RSP, rsp_data=data.
- RD_S (1 cycle): gwl[row]=1, read_en=1; sa sampled at end of cycle into rsp_data -> RSP.
- ACC_RD (1 cycle): rwl[row]=1; to_adder sampled at end of cycle.
- ACC_WR (1 cycle): {carry,sum} = sampled + data, WIDTH+1 bits, modulo 2^WIDTH stored; wwl[row]=1, from_adder=sum -> RSP, rsp_data=sum, rsp_carry=carry.
- RSP: rsp_valid=1, rsp_* held stable until rsp_ready; on handshake -> IDLE. cmd_ready=0 outside IDLE (no command overlap).
- Latency accept-to-rsp_valid: 2 cycles CLEAR/WRITE/READ, 3 cycles ACCUM, 1 cycle error.
- Reset mid-operation: pulses drop immediately, pending response discarded, cell contents undefined for the interrupted write.
- rsp_carry=0 and rsp_err=0 for all ops except as stated.

Decomposition:
- Package cim_pkg: op encoding constants (OP_CLEAR..OP_ACCUM), state enum typedef.
- Sub-module cim_row_decoder: row + enable -> ROWS-bit one-hot, all-zero when disabled or row >= ROWS; instantiated once, shared by all word-line groups.

Test Plan:
- Reset held 3 cycles, then released -> all array outputs 0, rsp_valid=0, cmd_ready=1.
- WRITE row 3 data 0xA5 (ROWS=8, WIDTH=8, behavioural stdCell bank) -> next cycle gwl=8'b0000_1000, write_en=1, bl=0xA5 for exactly 1 cycle; rsp_data=0xA5. Then READ row 3 -> gwl[3]+read_en pulse, rsp_data=0xA5.
- ACCUM row 3 addend 0x6B -> rwl[3] cycle, then wwl[3] with from_adder=0x10; rsp_data=0x10, rsp_carry=1, latency 3. READ row 3 -> 0x10.
- CLEAR row 3 with rsp_ready low 5 cycles -> clr[3] single pulse; rsp_valid/rsp_data=0 stable and cmd_ready=0 throughout; READ row 3 afterwards -> 0x00.
- ROWS=6 build, READ row 7 -> rsp_err=1 after 1 cycle, no rwl/wwl/gwl/clr activity.
- Assert rst during ACC_WR -> wwl drops same cycle, no rsp_valid; after release cmd_ready=1 and a new WRITE row 0 completes normally.
